register_bank_32: RTL

Architectural integer register file of the single-cycle RISC-V datapath, directly upstream of the 32-way register-select multiplexers. Holds 32 registers of `NrOfBits` bits, with one synchronous write port and x0 hard-wired to zero. All 32 registers are presented in parallel as `RegOut_0`..`RegOut_31`, which feed the mux inputs `MuxIn_0`..`MuxIn_31`. An embedded scan sequencer streams all registers, in order, over a valid/ready port to the debug/trace display after a halt.

---
 rtl/register_bank_32_pkg.sv | 12 +
 rtl/register_bank_32_if.sv | 22 ++
 rtl/register_bank_32_reg_scan_ctrl.sv | 91 +++++++++
 rtl/register_bank_32.sv | 87 ++++++++
 4 files changed

// File: rtl/register_bank_32_pkg.sv
// Shared constants and scan-sequencer state encoding for the register bank.
package register_bank_32_pkg;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] LAST_REG = 5'd31;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'b00,
    SCAN_OFFER = 2'b01,
    SCAN_DONE  = 2'b10
  } scan_state_e;
endpackage

// File: rtl/register_bank_32_if.sv
// Scan/dump port of the register bank: start request, valid/ready word stream, status.
interface register_bank_32_if #(parameter int NrOfBits = 32);
  import register_bank_32_pkg::*;

  logic                  ScanStart;
  logic                  ScanReady;
  logic                  ScanValid;
  logic [REG_ADDR_W-1:0] ScanIndex;
  logic [NrOfBits-1:0]   ScanData;
  logic                  ScanBusy;
  logic                  ScanDone;

  modport master (
    output ScanStart, ScanReady,
    input  ScanValid, ScanIndex, ScanData, ScanBusy, ScanDone
  );

  modport slave (
    input  ScanStart, ScanReady,
    output ScanValid, ScanIndex, ScanData, ScanBusy, ScanDone
  );
endinterface

// File: rtl/register_bank_32_reg_scan_ctrl.sv
// Scan sequencer: walks the pointer over all registers with a valid/ready handshake
// and tells the bank when and from which register to latch the next scan word.
module reg_scan_ctrl
  import register_bank_32_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  start_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [REG_ADDR_W-1:0] index_o,
  output logic [REG_ADDR_W-1:0] scan_sel_o,
  output logic                  load_o
);
  scan_state_e           state_q;
  logic [REG_ADDR_W-1:0] ptr_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;

  // valid_q is always set in OFFER, so ready alone marks a handshake there.
  always_comb begin
    load_o     = 1'b0;
    scan_sel_o = '0;
    case (state_q)
      SCAN_IDLE: begin
        load_o     = start_i;
        scan_sel_o = '0;
      end
      SCAN_OFFER: begin
        load_o     = ready_i && (ptr_q != LAST_REG);
        scan_sel_o = ptr_q + REG_ADDR_W'(1);
      end
      default: begin
        load_o     = 1'b0;
        scan_sel_o = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= SCAN_IDLE;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        SCAN_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= SCAN_OFFER;
            ptr_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SCAN_OFFER: begin
          if (ready_i) begin
            if (ptr_q == LAST_REG) begin
              state_q <= SCAN_DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              ptr_q <= ptr_q + REG_ADDR_W'(1);
            end
          end
        end
        SCAN_DONE: begin
          state_q <= SCAN_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= SCAN_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign index_o = ptr_q;
endmodule

// File: rtl/register_bank_32.sv
// Architectural integer register file (x0 hard-wired to zero) with all registers
// exposed in parallel and a snapshotting scan port for post-halt dumps.
module register_bank_32
  import register_bank_32_pkg::*;
#(
  parameter int NrOfBits = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WriteEnable,
  input  logic [REG_ADDR_W-1:0] WriteAddr,
  input  logic [NrOfBits-1:0]   WriteData,
  register_bank_32_if.slave     scan,
  output logic [NrOfBits-1:0]   RegOut_0,  RegOut_1,  RegOut_2,  RegOut_3,
  output logic [NrOfBits-1:0]   RegOut_4,  RegOut_5,  RegOut_6,  RegOut_7,
  output logic [NrOfBits-1:0]   RegOut_8,  RegOut_9,  RegOut_10, RegOut_11,
  output logic [NrOfBits-1:0]   RegOut_12, RegOut_13, RegOut_14, RegOut_15,
  output logic [NrOfBits-1:0]   RegOut_16, RegOut_17, RegOut_18, RegOut_19,
  output logic [NrOfBits-1:0]   RegOut_20, RegOut_21, RegOut_22, RegOut_23,
  output logic [NrOfBits-1:0]   RegOut_24, RegOut_25, RegOut_26, RegOut_27,
  output logic [NrOfBits-1:0]   RegOut_28, RegOut_29, RegOut_30, RegOut_31
);
  logic [NrOfBits-1:0]   reg_vals [REG_COUNT];
  logic [NrOfBits-1:0]   scan_data_q;
  logic [REG_ADDR_W-1:0] scan_sel;
  logic                  scan_load;

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign reg_vals[gi] = '0;
      end else begin : g_flop
        logic [NrOfBits-1:0] value_q;
        always_ff @(posedge Clock) begin
          if (Reset) begin
            value_q <= '0;
          end else if (WriteEnable && (WriteAddr == REG_ADDR_W'(gi))) begin
            value_q <= WriteData;
          end
        end
        assign reg_vals[gi] = value_q;
      end
    end
  endgenerate

  reg_scan_ctrl u_scan_ctrl (
    .clk_i      (Clock),
    .srst_i     (Reset),
    .start_i    (scan.ScanStart),
    .ready_i    (scan.ScanReady),
    .valid_o    (scan.ScanValid),
    .busy_o     (scan.ScanBusy),
    .done_o     (scan.ScanDone),
    .index_o    (scan.ScanIndex),
    .scan_sel_o (scan_sel),
    .load_o     (scan_load)
  );

  // Latching from the pre-edge array makes a same-edge write invisible to the offered word.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      scan_data_q <= '0;
    end else if (scan_load) begin
      scan_data_q <= reg_vals[scan_sel];
    end
  end

  assign scan.ScanData = scan_data_q;

  assign RegOut_0  = reg_vals[0];  assign RegOut_1  = reg_vals[1];
  assign RegOut_2  = reg_vals[2];  assign RegOut_3  = reg_vals[3];
  assign RegOut_4  = reg_vals[4];  assign RegOut_5  = reg_vals[5];
  assign RegOut_6  = reg_vals[6];  assign RegOut_7  = reg_vals[7];
  assign RegOut_8  = reg_vals[8];  assign RegOut_9  = reg_vals[9];
  assign RegOut_10 = reg_vals[10]; assign RegOut_11 = reg_vals[11];
  assign RegOut_12 = reg_vals[12]; assign RegOut_13 = reg_vals[13];
  assign RegOut_14 = reg_vals[14]; assign RegOut_15 = reg_vals[15];
  assign RegOut_16 = reg_vals[16]; assign RegOut_17 = reg_vals[17];
  assign RegOut_18 = reg_vals[18]; assign RegOut_19 = reg_vals[19];
  assign RegOut_20 = reg_vals[20]; assign RegOut_21 = reg_vals[21];
  assign RegOut_22 = reg_vals[22]; assign RegOut_23 = reg_vals[23];
  assign RegOut_24 = reg_vals[24]; assign RegOut_25 = reg_vals[25];
  assign RegOut_26 = reg_vals[26]; assign RegOut_27 = reg_vals[27];
  assign RegOut_28 = reg_vals[28]; assign RegOut_29 = reg_vals[29];
  assign RegOut_30 = reg_vals[30]; assign RegOut_31 = reg_vals[31];
endmodule
